pmp_check_arbiter: RTL and testbench
====================================

Name: pmp_check_arbiter

Overview:
- Shares one combinational pmp checker instance between NR_REQ requesters, e.g. AXI AR and AW address channels.
- Each requester issues a check (address, access type, privilege) over valid/ready and receives a registered allow/deny response over valid/ready.
- Requesters are granted round-robin, one check in flight at a time.
- Also provides a config-stall input so pmpcfg/pmpaddr rewrites never race an in-flight check, plus a saturating deny counter.

Parameters:
- NR_REQ, 2, number of requesters (2..8).
- PLEN, 34, physical address width.
- CNT_W, 16, deny counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NR_REQ  per-requester check request.
- req_ready_o  out  NR_REQ  per-requester request accepted (one-hot or zero).
- req_addr_i  in  NR_REQ x PLEN  address to check.
- req_access_i  in  NR_REQ x 3  riscv::pmp_access_t.
- req_priv_i  in  NR_REQ x 2  riscv::priv_lvl_t.
- rsp_valid_o  out  NR_REQ  response valid for the owning requester (one-hot or zero).
- rsp_ready_i  in  NR_REQ  requester accepts response.
- rsp_allow_o  out  1  1 = access permitted, valid when any rsp_valid_o is set.
- pmp_addr_o  out  PLEN  to shared pmp addr_i.
- pmp_access_o  out  3  to shared pmp access_type_i.
- pmp_priv_o  out  2  to shared pmp priv_lvl_i.
- pmp_allow_i  in  1  from shared pmp allow_o.
- cfg_stall_i  in  1  CSR write pending; block new grants.
- cfg_idle_o  out  1  no check in flight (state IDLE); CSR may update config.
- deny_cnt_o  out  CNT_W  saturating count of denied checks.
- deny_clr_i  in  1  synchronous clear of deny_cnt_o.

Behaviour:
- Reset values (async, rst_i high):
  - state=IDLE, rr_ptr=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_allow_o=0.
  - pmp_addr_o/pmp_access_o/pmp_priv_o = 0 (registered capture).
  - cfg_idle_o=1, deny_cnt_o=0.
- IDLE:
  - If cfg_stall_i=0 and any req_valid_i, select the first valid index starting at rr_ptr, wrapping modulo NR_REQ.
  - req_ready_o[g] is asserted combinationally this cycle; the handshake completes.
  - Capture addr/access/priv into pmp_*_o registers and g into owner; rr_ptr <= (g+1) mod NR_REQ.
  - Next state CHECK. If cfg_stall_i=1, no grant; all req_ready_o=0.
- CHECK (one cycle): pmp_*_o stable from capture.
  - Register rsp_allow_o <= pmp_allow_i.
  - If pmp_allow_i=0, increment deny_cnt_o, saturating at all-ones.
  - Next state RESP.
- RESP:
  - rsp_valid_o[owner]=1; rsp_allow_o held.
  - On rsp_ready_i[owner]=1, go to IDLE. rsp_valid_o drops the next cycle; no new grant in the handshake cycle.
  - Otherwise hold indefinitely; rsp_ready_i of non-owners is ignored.
- Latency: accept at cycle T, response valid at T+2. Max throughput: 1 check per 3 cycles.
- cfg_idle_o = (state==IDLE). cfg_stall_i only blocks grants in IDLE; a check already in CHECK/RESP completes against the config present during its CHECK cycle.
- Response handshake:
  - A requester must not drop req_valid_i before ready, and must keep its inputs stable while valid; the block does not check this.
  - Only the granted requester sees req_ready_o.
- Deny counter:
  - deny_clr_i has priority over an increment in the same cycle; the counter becomes 0.
- Simultaneous requests: round-robin guarantees each valid requester is granted within NR_REQ grants.
- Reset mid-operation: everything returns to reset values immediately. An outstanding response is lost; requesters must re-issue.

Test Plan:
- Single request, requester 0: addr=0x8000_0000, access=R, priv=U, pmp_allow_i=1 → req_ready_o[0] at T, rsp_valid_o=01 with rsp_allow_o=1 at T+2, deny_cnt_o=0.
- Both requesters continuously valid, rsp_ready_i=11 → grants alternate 0,1,0,1 every 3 cycles; rr_ptr wraps; no starvation over 8 grants.
- pmp_allow_i=0 for 3 checks, then deny_clr_i=1 coincident with a 4th deny → deny_cnt_o reads 3, then 0 (clear wins). Preload CNT_W=4 with 20 denies → saturates at 15.
- rsp_ready_i[owner]=0 for 5 cycles while the other requester is valid → rsp_valid_o and rsp_allow_o held; no new req_ready_o until the response handshake completes.
- cfg_stall_i=1 while in CHECK → that check completes normally; in IDLE with requests pending, req_ready_o stays 0 and cfg_idle_o=1 until stall drops; grant follows in the first cycle after stall=0.
- Assert rst_i during RESP → rsp_valid_o=0 and state=IDLE immediately (async); after release, the same request is regranted with latency 2.

Source files
------------

// File: rtl/pmp_check_arbiter.sv
// ---------------------------------------------------------------------------
// pmp_check_arbiter
//
// Shares one combinational PMP checker between NR_REQ requesters, such as the
// AXI AR and AW address channels. Each requester sends a check request over
// valid/ready. The request carries an address, an access type and a privilege
// level. The requester gets back a registered allow/deny response over
// valid/ready.
//
// Requesters are granted round-robin, and only one check is in flight at a
// time. The sequence is IDLE -> CHECK -> RESP -> IDLE:
//   - A request accepted in cycle T has its response valid in cycle T+2.
//   - The best throughput is one check every three cycles.
//
// Configuration handshake:
//   - cfg_stall_i blocks new grants, so a pmpcfg/pmpaddr rewrite never races
//     an in-flight check.
//   - cfg_idle_o tells the CSR side that the checker is quiescent.
//
// A saturating counter records how many checks were denied.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   req_valid_i     per-requester check request
//   req_ready_o     per-requester accept (one-hot or zero), combinational
//   req_addr_i      per-requester physical address
//   req_access_i    per-requester access type (riscv::pmp_access_t encoding)
//   req_priv_i      per-requester privilege level (riscv::priv_lvl_t encoding)
//   rsp_valid_o     response valid for the owning requester (one-hot or zero)
//   rsp_ready_i     per-requester response accept
//   rsp_allow_o     1 = access permitted; meaningful while rsp_valid_o != 0
//   pmp_addr_o      registered address to the shared checker
//   pmp_access_o    registered access type to the shared checker
//   pmp_priv_o      registered privilege to the shared checker
//   pmp_allow_i     verdict from the shared checker
//   cfg_stall_i     CSR write pending; no new grant while high
//   cfg_idle_o      no check in flight; config may be updated
//   deny_cnt_o      saturating count of denied checks
//   deny_clr_i      synchronous clear of deny_cnt_o (wins over an increment)
// ---------------------------------------------------------------------------
module pmp_check_arbiter #(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned PLEN   = 34,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_REQ-1:0]            req_valid_i,
  output logic [NR_REQ-1:0]            req_ready_o,
  input  logic [NR_REQ-1:0][PLEN-1:0]  req_addr_i,
  input  logic [NR_REQ-1:0][2:0]       req_access_i,
  input  logic [NR_REQ-1:0][1:0]       req_priv_i,
  output logic [NR_REQ-1:0]            rsp_valid_o,
  input  logic [NR_REQ-1:0]            rsp_ready_i,
  output logic                         rsp_allow_o,
  output logic [PLEN-1:0]              pmp_addr_o,
  output logic [2:0]                   pmp_access_o,
  output logic [1:0]                   pmp_priv_o,
  input  logic                         pmp_allow_i,
  input  logic                         cfg_stall_i,
  output logic                         cfg_idle_o,
  output logic [CNT_W-1:0]             deny_cnt_o,
  input  logic                         deny_clr_i
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [NR_REQ-1:0] grant_oh;
  logic              grant_fire;
  logic [IDX_W-1:0]  rr_next;
  logic              rsp_fire;

  // Round-robin pick. The search starts at rr_ptr and wraps modulo NR_REQ.
  // The candidate sum is one bit wider than an index, so a single conditional
  // subtract performs the wrap. This also works when NR_REQ is not a power
  // of two.
  always_comb begin
    logic [IDX_W:0] cand_wide;
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_wide   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand_wide = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand_wide >= (IDX_W+1)'(NR_REQ)) begin
        cand_wide = cand_wide - (IDX_W+1)'(NR_REQ);
      end
      cand = cand_wide[IDX_W-1:0];
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer for the next arbitration round: the slot after the winner.
  always_comb begin
    logic [IDX_W:0] inc;
    inc = {1'b0, grant_idx} + (IDX_W+1)'(1);
    if (inc >= (IDX_W+1)'(NR_REQ)) begin
      inc = '0;
    end
    rr_next = inc[IDX_W-1:0];
  end

  // Grant handshake.
  // - A grant happens only in IDLE with no config stall pending.
  // - Reset is folded in so that req_ready_o reads zero while rst_i is held.
  //   Otherwise a requester could believe it was accepted during reset.
  assign grant_fire = (state == ST_IDLE) && !cfg_stall_i && grant_found && !rst_i;

  always_comb begin
    grant_oh = '0;
    grant_oh[grant_idx] = 1'b1;
    req_ready_o = grant_fire ? grant_oh : '0;
  end

  // The response is offered only to the requester that owns the in-flight
  // check. The rsp_ready_i inputs of other requesters are ignored.
  always_comb begin
    rsp_valid_o = '0;
    if (state == ST_RESP) begin
      rsp_valid_o[owner] = 1'b1;
    end
  end

  assign rsp_fire   = (state == ST_RESP) && rsp_ready_i[owner];
  assign cfg_idle_o = (state == ST_IDLE);

  // Main sequencer.
  // - The checker inputs are captured at grant time, so the shared checker
  //   sees stable inputs for the whole CHECK cycle.
  // - The verdict is registered at the end of CHECK and held through RESP.
  // - Leaving RESP returns to IDLE without granting in the same cycle.
  //   A new grant therefore always sees the post-handshake state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      rsp_allow_o  <= 1'b0;
      pmp_addr_o   <= '0;
      pmp_access_o <= '0;
      pmp_priv_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            pmp_addr_o   <= req_addr_i[grant_idx];
            pmp_access_o <= req_access_i[grant_idx];
            pmp_priv_o   <= req_priv_i[grant_idx];
            owner        <= grant_idx;
            rr_ptr       <= rr_next;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          rsp_allow_o <= pmp_allow_i;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Deny counter.
  // - It counts a deny only in the CHECK cycle, where the verdict is sampled.
  // - It saturates at all-ones instead of wrapping.
  // - A clear in the same cycle wins over an increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deny_cnt_o <= '0;
    end else if (deny_clr_i) begin
      deny_cnt_o <= '0;
    end else if ((state == ST_CHECK) && !pmp_allow_i &&
                 (deny_cnt_o != {CNT_W{1'b1}})) begin
      deny_cnt_o <= deny_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmp_check_arbiter
//
// Directed testbench for pmp_check_arbiter with two requesters. It uses two
// DUT instances that share all stimulus:
//   - dut uses the default 16-bit deny counter.
//   - dut_sat uses a 4-bit deny counter, so saturation is reachable in a
//     short run.
// Each scenario task drives its own stimulus and compares DUT outputs with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_pmp_check_arbiter;

  localparam int unsigned NR_REQ = 2;
  localparam int unsigned PLEN   = 34;

  logic                        clk_i;
  logic                        rst_i;
  logic [NR_REQ-1:0]           req_valid;
  logic [NR_REQ-1:0][PLEN-1:0] req_addr;
  logic [NR_REQ-1:0][2:0]      req_access;
  logic [NR_REQ-1:0][1:0]      req_priv;
  logic [NR_REQ-1:0]           rsp_ready;
  logic                        pmp_allow;
  logic                        cfg_stall;
  logic                        deny_clr;

  logic [NR_REQ-1:0]           req_ready;
  logic [NR_REQ-1:0]           rsp_valid;
  logic                        rsp_allow;
  logic [PLEN-1:0]             pmp_addr;
  logic [2:0]                  pmp_access;
  logic [1:0]                  pmp_priv;
  logic                        cfg_idle;
  logic [15:0]                 deny_cnt;

  logic [NR_REQ-1:0]           s_req_ready;
  logic [NR_REQ-1:0]           s_rsp_valid;
  logic                        s_rsp_allow;
  logic [PLEN-1:0]             s_pmp_addr;
  logic [2:0]                  s_pmp_access;
  logic [1:0]                  s_pmp_priv;
  logic                        s_cfg_idle;
  logic [3:0]                  s_deny_cnt;

  int tests_run;
  int tests_failed;

  pmp_check_arbiter #(.NR_REQ(NR_REQ), .PLEN(PLEN), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_access_i(req_access), .req_priv_i(req_priv),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
    .pmp_addr_o(pmp_addr), .pmp_access_o(pmp_access), .pmp_priv_o(pmp_priv),
    .pmp_allow_i(pmp_allow), .cfg_stall_i(cfg_stall), .cfg_idle_o(cfg_idle),
    .deny_cnt_o(deny_cnt), .deny_clr_i(deny_clr)
  );

  pmp_check_arbiter #(.NR_REQ(NR_REQ), .PLEN(PLEN), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready),
    .req_addr_i(req_addr), .req_access_i(req_access), .req_priv_i(req_priv),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(s_rsp_allow),
    .pmp_addr_o(s_pmp_addr), .pmp_access_o(s_pmp_access), .pmp_priv_o(s_pmp_priv),
    .pmp_allow_i(pmp_allow), .cfg_stall_i(cfg_stall), .cfg_idle_o(s_cfg_idle),
    .deny_cnt_o(s_deny_cnt), .deny_clr_i(deny_clr)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    cfg_stall = 1'b0;
    deny_clr  = 1'b0;
    rst_i     = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    cfg_stall = 1'b0;
    deny_clr  = 1'b0;
    pmp_allow = 1'b1;
    rst_i     = 1'b1;
    #2;
    tests_run++;
    if (req_ready !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
    tests_run++;
    if (rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    tests_run++;
    if (rsp_allow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_allow: got %b expected 0", rsp_allow); end
    tests_run++;
    if (pmp_addr !== 34'h0 || pmp_access !== 3'b000 || pmp_priv !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_pmp_regs: got %h/%b/%b expected 0/000/00", pmp_addr, pmp_access, pmp_priv);
    end
    tests_run++;
    if (cfg_idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cfg_idle: got %b expected 1", cfg_idle); end
    tests_run++;
    if (deny_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_deny_cnt: got %0d expected 0", deny_cnt); end
    tick();
    req_valid = 2'b00;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    pmp_allow = 1'b1;
    req_valid = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (pmp_addr !== 34'h0_8000_0000 || pmp_access !== 3'b001 || pmp_priv !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL single_capture: got %h/%b/%b expected 080000000/001/00", pmp_addr, pmp_access, pmp_priv);
    end
    tests_run++;
    if (cfg_idle !== 1'b0 || rsp_valid !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL single_check_cycle: got idle=%b rsp_valid=%b expected idle=0 rsp_valid=00", cfg_idle, rsp_valid);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_response: got rsp_valid=%b allow=%b expected 01/1", rsp_valid, rsp_allow);
    end
    tests_run++;
    if (deny_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL single_deny_cnt: got %0d expected 0", deny_cnt); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b00 || cfg_idle !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_done: got rsp_valid=%b idle=%b expected 00/1", rsp_valid, cfg_idle);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    do_reset();
    pmp_allow = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int g = 0; g < 8; g++) begin
      exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++;
      if (req_ready !== exp_oh) begin tests_failed++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", g, req_ready, exp_oh); end
      tick();
      tests_run++;
      if (pmp_addr !== req_addr[g % 2]) begin tests_failed++; $display("[TB] FAIL rr_addr_%0d: got %h expected %h", g, pmp_addr, req_addr[g % 2]); end
      tick();
      tests_run++;
      if (rsp_valid !== exp_oh) begin tests_failed++; $display("[TB] FAIL rr_rsp_%0d: got %b expected %b", g, rsp_valid, exp_oh); end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_deny();
    int exp;
    do_reset();
    pmp_allow = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) deny_clr = 1'b1;
      tick();
      deny_clr = 1'b0;
      exp = (k == 4) ? 0 : k;
      tests_run++;
      if (deny_cnt !== 16'(exp)) begin tests_failed++; $display("[TB] FAIL deny_cnt_%0d: got %0d expected %0d", k, deny_cnt, exp); end
      tests_run++;
      if (rsp_allow !== 1'b0 || rsp_valid !== 2'b01) begin
        tests_failed++; $display("[TB] FAIL deny_rsp_%0d: got allow=%b valid=%b expected 0/01", k, rsp_allow, rsp_valid);
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_saturate();
    do_reset();
    pmp_allow = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tick();
      if (k == 15) begin
        tests_run++;
        if (s_deny_cnt !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_at_15: got %0d expected 15", s_deny_cnt); end
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tests_run++;
    if (s_deny_cnt !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_hold: got %0d expected 15", s_deny_cnt); end
    tests_run++;
    if (deny_cnt !== 16'd20) begin tests_failed++; $display("[TB] FAIL sat_wide_cnt: got %0d expected 20", deny_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    pmp_allow = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL bp_first_grant: got %b expected 01", req_ready); end
    tick();
    tick();
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1 || req_ready !== 2'b00) begin
        tests_failed++; $display("[TB] FAIL bp_hold_%0d: got valid=%b allow=%b ready=%b expected 01/1/00", c, rsp_valid, rsp_allow, req_ready);
      end
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL bp_handshake_cycle: got ready=%b valid=%b expected 00/01", req_ready, rsp_valid);
    end
    tick();
    rsp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL bp_next_grant: got ready=%b valid=%b expected 10/00", req_ready, rsp_valid);
    end
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_cfg_stall();
    do_reset();
    pmp_allow = 1'b1;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL stall_first_grant: got %b expected 01", req_ready); end
    tick();
    cfg_stall = 1'b1;
    #1;
    tests_run++;
    if (cfg_idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_check_busy: got %b expected 0", cfg_idle); end
    tick();
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL stall_inflight_done: got valid=%b allow=%b expected 01/1", rsp_valid, rsp_allow);
    end
    tick();
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (req_ready !== 2'b00 || cfg_idle !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL stall_blocked_%0d: got ready=%b idle=%b expected 00/1", c, req_ready, cfg_idle);
      end
      tick();
    end
    cfg_stall = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL stall_release_grant: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (pmp_addr !== req_addr[1] || pmp_access !== 3'b010 || pmp_priv !== 2'b11) begin
      tests_failed++; $display("[TB] FAIL stall_release_capture: got %h/%b/%b expected %h/010/11", pmp_addr, pmp_access, pmp_priv, req_addr[1]);
    end
    rsp_ready = 2'b11;
    tick();
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pmp_allow = 1'b1;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick();
    tick();
    tests_run++;
    if (rsp_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL rmid_in_resp: got %b expected 01", rsp_valid); end
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 2'b00 || cfg_idle !== 1'b1 || req_ready !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL rmid_async: got valid=%b idle=%b ready=%b expected 00/1/00", rsp_valid, cfg_idle, req_ready);
    end
    #1;
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL rmid_regrant: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL rmid_check_cycle: got %b expected 00", rsp_valid); end
    tick();
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rmid_response: got valid=%b allow=%b expected 01/1", rsp_valid, rsp_allow);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    req_valid    = '0;
    rsp_ready    = '0;
    pmp_allow    = 1'b1;
    cfg_stall    = 1'b0;
    deny_clr     = 1'b0;
    req_addr[0]   = 34'h0_8000_0000;
    req_access[0] = 3'b001;
    req_priv[0]   = 2'b00;
    req_addr[1]   = 34'h2_4000_1000;
    req_access[1] = 3'b010;
    req_priv[1]   = 2'b11;

    test_reset();
    test_single();
    test_round_robin();
    test_deny();
    test_saturate();
    test_backpressure();
    test_cfg_stall();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
